// File: rtl/zlib_pkg.sv
// Shared definitions for the zlib Adler-32 sequencer and its checksum engine.
// Holds the FSM state encoding, checksum constants and the byte update helper.
package zlib_pkg;

   localparam int          DATA_WD        = 32;
   localparam int          ADLER_WAIT_CYC = 3;
   localparam int          ADLER_MOD      = 65521;
   localparam logic [31:0] ADLER_INIT     = 32'h0000_0001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FEED,
      S_WAIT,
      S_LWAIT,
      S_TRAIL
   } state_t;

   // One Adler-32 byte step; returns {s2, s1} reduced modulo 65521.
   function automatic logic [31:0] adler_step(
      input logic [15:0] s1,
      input logic [15:0] s2,
      input logic [7:0]  b
   );
      logic [16:0] a;
      logic [16:0] c;
      a = {1'b0, s1} + {9'd0, b};
      if (a >= 17'(ADLER_MOD)) a = a - 17'(ADLER_MOD);
      c = {1'b0, s2} + a;
      if (c >= 17'(ADLER_MOD)) c = c - 17'(ADLER_MOD);
      return {c[15:0], a[15:0]};
   endfunction

endpackage

// File: rtl/zlib_adler_ctrl_adler32.sv
// Byte-serial Adler-32 engine: first byte folds on the accept edge,
// the remaining three bytes on the following three cycles.
module zlib_adler_ctrl_adler32 (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        val,
   input  logic [31:0] dat,
   input  logic        lst,
   output logic        rdy,
   output logic [31:0] sum,
   output logic        sum_vld
);
   import zlib_pkg::*;

   logic [15:0] s1;
   logic [15:0] s2;
   logic [23:0] rest;
   logic [1:0]  cnt;
   logic        lst_q;

   assign rdy     = (cnt == 2'd0);
   assign sum     = {s2, s1};
   assign sum_vld = lst_q && rdy;

   // Running sums, pending bytes of the current word and last-word flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1    <= ADLER_INIT[15:0];
         s2    <= ADLER_INIT[31:16];
         rest  <= '0;
         cnt   <= '0;
         lst_q <= 1'b0;
      end else if (start) begin
         s1    <= ADLER_INIT[15:0];
         s2    <= ADLER_INIT[31:16];
         rest  <= '0;
         cnt   <= '0;
         lst_q <= 1'b0;
      end else if (val) begin
         {s2, s1} <= adler_step(s1, s2, dat[31:24]);
         rest     <= dat[23:0];
         cnt      <= 2'd3;
         lst_q    <= lst;
      end else if (cnt != 2'd0) begin
         {s2, s1} <= adler_step(s1, s2, rest[23:16]);
         rest     <= {rest[15:0], 8'h00};
         cnt      <= cnt - 2'd1;
      end
   end

endmodule

// File: rtl/zlib_adler_ctrl.sv
// zlib stream sequencer: forwards payload words, paces the Adler-32 engine
// and appends the checksum trailer. Option: ZLIB_ADLER_CTRL_LEN_CNT_EN adds len_o.
module zlib_adler_ctrl #(
   parameter int DATA_WD  = 32,
   parameter int WAIT_CYC = 3
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               in_val_i,
   output logic               in_rdy_o,
   input  logic [DATA_WD-1:0] in_dat_i,
   input  logic               in_lst_i,
   output logic               out_val_o,
   input  logic               out_rdy_i,
   output logic [DATA_WD-1:0] out_dat_o,
   output logic               out_lst_o,
   output logic               busy_o,
   output logic               done_o
`ifdef ZLIB_ADLER_CTRL_LEN_CNT_EN
   ,
   output logic [31:0]        len_o
`endif
);
   import zlib_pkg::*;

   localparam logic [1:0] CNT_LAST = 2'(WAIT_CYC - 1);

   state_t      state;
   logic [1:0]  cnt;
   logic        free;
   logic        acc;
   logic        ld_trl;
   logic        trl_hs;
   logic        eng_start;
   logic        eng_rdy;
   logic        eng_vld;
   logic [31:0] eng_dat;
   logic [31:0] eng_sum;

   assign free      = !out_val_o || out_rdy_i;
   assign in_rdy_o  = (state == S_FEED) && free;
   assign acc       = in_val_i && in_rdy_o;
   assign eng_start = (state == S_IDLE) && start_i;
   assign eng_dat   = (state == S_FEED) ? in_dat_i : '0;
   assign ld_trl    = (state == S_TRAIL) && eng_vld &&
                      !out_lst_o && free;
   assign trl_hs    = (state == S_TRAIL) && out_val_o &&
                      out_lst_o && out_rdy_i;

   zlib_adler_ctrl_adler32 u_adler32 (
      .clk     (clk),
      .rstn    (rstn),
      .start   (eng_start),
      .val     (acc),
      .dat     (eng_dat),
      .lst     (in_lst_i),
      .rdy     (eng_rdy),
      .sum     (eng_sum),
      .sum_vld (eng_vld)
   );

   // Frame FSM with the one-entry output register and status outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         out_val_o <= 1'b0;
         out_dat_o <= '0;
         out_lst_o <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (acc) begin
            out_val_o <= 1'b1;
            out_dat_o <= in_dat_i;
            out_lst_o <= 1'b0;
         end else if (ld_trl) begin
            out_val_o <= 1'b1;
            out_dat_o <= eng_sum;
            out_lst_o <= 1'b1;
         end else if (out_rdy_i) begin
            out_val_o <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (start_i) begin
                  state  <= S_ARM;
                  busy_o <= 1'b1;
                  cnt    <= '0;
               end
            end
            S_ARM: begin
               if (eng_rdy) state <= S_FEED;
            end
            S_FEED: begin
               if (acc) begin
                  state <= in_lst_i ? S_LWAIT : S_WAIT;
                  cnt   <= '0;
               end
            end
            S_WAIT: begin
               if (cnt == CNT_LAST) begin
                  state <= S_FEED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_LWAIT: begin
               if (cnt == CNT_LAST) begin
                  state <= S_TRAIL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_TRAIL: begin
               if (trl_hs) begin
                  state     <= S_IDLE;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  out_lst_o <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ZLIB_ADLER_CTRL_LEN_CNT_EN
   localparam logic [31:0] LEN_MAX = 32'hFFFF_FFFC;

   // Saturating payload byte count, cleared when a frame starts.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_o <= '0;
      end else if (eng_start) begin
         len_o <= '0;
      end else if (acc && (len_o != LEN_MAX)) begin
         len_o <= len_o + 32'd4;
      end
   end
`endif

endmodule

// File: tb/tb_zlib_adler_ctrl.sv
// Self-checking bench for zlib_adler_ctrl: behavioural Adler-32 model,
// expected-word queue and a per-cycle compare process.
module tb_zlib_adler_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_i = 1'b0;
   logic        in_val_i = 1'b0;
   logic        in_rdy_o;
   logic [31:0] in_dat_i = '0;
   logic        in_lst_i = 1'b0;
   logic        out_val_o;
   logic        out_rdy_i = 1'b1;
   logic [31:0] out_dat_o;
   logic        out_lst_o;
   logic        busy_o;
   logic        done_o;
`ifdef ZLIB_ADLER_CTRL_LEN_CNT_EN
   logic [31:0] len_o;
`endif

   zlib_adler_ctrl dut (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (start_i),
      .in_val_i  (in_val_i),
      .in_rdy_o  (in_rdy_o),
      .in_dat_i  (in_dat_i),
      .in_lst_i  (in_lst_i),
      .out_val_o (out_val_o),
      .out_rdy_i (out_rdy_i),
      .out_dat_o (out_dat_o),
      .out_lst_o (out_lst_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
`ifdef ZLIB_ADLER_CTRL_LEN_CNT_EN
      ,
      .len_o     (len_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [32:0] act,
                      input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] adler_ref(input logic [31:0] w[$]);
      int unsigned a = 1;
      int unsigned b = 0;
      foreach (w[i])
         for (int k = 3; k >= 0; k--) begin
            a = (a + ((w[i] >> (8 * k)) & 32'hFF)) % 65521;
            b = (b + a) % 65521;
         end
      return {b[15:0], a[15:0]};
   endfunction

   logic [32:0] expq[$];
   int          rdy_mode = 0;
   int          stall_end = 0;

   // Downstream ready pattern.
   always @(posedge clk) begin
      #1;
      if (cyc < stall_end) out_rdy_i = 1'b0;
      else if (rdy_mode == 1) out_rdy_i = 1'($urandom_range(0, 1));
      else out_rdy_i = 1'b1;
   end

   logic        pv = 0, pr = 0, hs_prev = 0, acc_prev = 0;
   logic [31:0] pd = '0, acc_dat = '0, last_trailer = '0;
   int          acc_cyc = 0, trail_cyc = 0, dones = 0;

   // Per-cycle compare of DUT outputs against the model.
   always @(negedge clk) begin
      if (!rstn) begin
         pv = 0; pr = 0; hs_prev = 0; acc_prev = 0;
      end else begin
         chk("done_pulse", 33'(done_o), 33'(hs_prev));
         if (done_o) dones++;
         if (pv && !pr) begin
            chk("hold_val", 33'(out_val_o), 33'd1);
            chk("hold_dat", 33'(out_dat_o), 33'(pd));
         end
         if (out_val_o && !out_rdy_i)
            chk("stall_in_rdy", 33'(in_rdy_o), 33'd0);
         if (acc_prev) begin
            chk("val_t1", 33'(out_val_o), 33'd1);
            chk("dat_t1", 33'(out_dat_o), 33'(acc_dat));
         end
         hs_prev = 0;
         if (out_val_o && out_rdy_i) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got %h want none",
                        {out_lst_o, out_dat_o});
            end else begin
               chk("out_word", {out_lst_o, out_dat_o}, expq.pop_front());
            end
            if (out_lst_o) begin
               hs_prev = 1;
               trail_cyc = cyc;
               last_trailer = out_dat_o;
            end
         end
         acc_prev = in_val_i && in_rdy_o;
         if (acc_prev) begin
            acc_dat = in_dat_i;
            acc_cyc = cyc;
         end
         pv = out_val_o; pr = out_rdy_i; pd = out_dat_o;
      end
   end

   int nframes = 0;

   task automatic chk_zero(input string tag);
      chk({tag, "_in_rdy"}, 33'(in_rdy_o), 33'd0);
      chk({tag, "_out_val"}, 33'(out_val_o), 33'd0);
      chk({tag, "_out_dat"}, 33'(out_dat_o), 33'd0);
      chk({tag, "_out_lst"}, 33'(out_lst_o), 33'd0);
      chk({tag, "_busy"}, 33'(busy_o), 33'd0);
      chk({tag, "_done"}, 33'(done_o), 33'd0);
   endtask

   task automatic send_frame(input logic [31:0] w[$], input bit gaps,
                             input bit poke, input bit tchk,
                             input bit rst_lw, input bit stall);
      int bound;
      int s;
      int prev_acc;
      bound = 0;
      while (busy_o && bound < 300) begin
         @(posedge clk); #1; bound++;
      end
      foreach (w[i]) expq.push_back({1'b0, w[i]});
      if (!rst_lw) expq.push_back({1'b1, adler_ref(w)});
      start_i = 1'b1;
      @(posedge clk); #1;
      s = cyc - 1;
      start_i = 1'b0;
      prev_acc = 0;
      foreach (w[i]) begin
         if (gaps) repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         in_val_i = 1'b1;
         in_dat_i = w[i];
         in_lst_i = (i == w.size() - 1);
         bound = 0;
         do begin
            @(negedge clk); bound++;
         end while (!in_rdy_o && bound < 200);
         if (!in_rdy_o) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no in_rdy want in_rdy");
            in_val_i = 1'b0;
            return;
         end
         @(posedge clk); #1;
         in_val_i = 1'b0;
         in_lst_i = 1'b0;
         if (tchk) begin
            if (i == 0) chk("start_to_rdy", 33'(acc_cyc - s), 33'd2);
            else chk("rdy_gap", 33'(acc_cyc - prev_acc), 33'd4);
         end
         prev_acc = acc_cyc;
         if (stall && i == 0) stall_end = cyc + 10;
         if (poke && i == 0 && w.size() > 1) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
         end
      end
      if (rst_lw) begin
         rstn = 1'b0;
         @(negedge clk);
         chk_zero("rst_lwait");
         @(posedge clk); #1;
         rstn = 1'b1;
         expq.delete();
         return;
      end
      if (poke) begin
         repeat (3) @(posedge clk);
         #1 start_i = 1'b1;
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      bound = 0;
      do begin
         @(negedge clk); bound++;
      end while (!done_o && bound < 400);
      if (!done_o) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done want done");
         return;
      end
      nframes++;
      if (tchk) chk("trail_lat", 33'(trail_cyc - acc_cyc), 33'd5);
`ifdef ZLIB_ADLER_CTRL_LEN_CNT_EN
      chk("len", 33'(len_o), 33'(4 * w.size()));
`endif
   endtask

   logic [31:0] q[$];
   logic [31:0] ref_tr;

   initial begin
      chk("ref_abcd", 33'(adler_ref('{32'h61626364})), 33'h03D8018B);
      chk("ref_zero", 33'(adler_ref('{32'h0, 32'h0})), 33'h00080001);
      chk("ref_ones", 33'(adler_ref('{32'hFFFFFFFF})), 33'h09FA03FD);

      repeat (2) @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk); #1;

      q = '{32'h61626364};
      send_frame(q, 0, 0, 1, 0, 0);
      chk("trailer_abcd", 33'(last_trailer), 33'h03D8018B);

      q = '{32'h0, 32'h0};
      send_frame(q, 0, 0, 1, 0, 0);
      chk("trailer_zero", 33'(last_trailer), 33'h00080001);

      q = '{32'hFFFFFFFF};
      send_frame(q, 0, 0, 1, 0, 0);
      chk("trailer_ones", 33'(last_trailer), 33'h09FA03FD);

      q = '{32'h12345678, 32'h9ABCDEF0, 32'h0BADCAFE};
      send_frame(q, 0, 0, 1, 0, 0);
      ref_tr = last_trailer;
      send_frame(q, 0, 0, 0, 0, 1);
      chk("stall_trailer", 33'(last_trailer), 33'(ref_tr));

      q = '{32'hDEADBEEF, 32'h01020304, 32'hA5A5A5A5};
      send_frame(q, 0, 1, 0, 0, 0);
      chk("poke_trailer", 33'(last_trailer), 33'(adler_ref(q)));

      q = '{32'h11111111, 32'h22222222};
      send_frame(q, 0, 0, 0, 1, 0);
      repeat (8) @(negedge clk);
      chk("post_rst_idle", 33'(busy_o), 33'd0);
      q = '{32'h61626364};
      send_frame(q, 0, 0, 1, 0, 0);
      chk("post_rst_trailer", 33'(last_trailer), 33'h03D8018B);

      q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
      send_frame(q, 0, 0, 1, 0, 0);

      rdy_mode = 1;
      for (int f = 0; f < 25; f++) begin
         q.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            q.push_back($urandom);
         send_frame(q, 1, 0, 0, 0, 0);
      end
      rdy_mode = 0;

      repeat (5) @(negedge clk);
      chk("queue_empty", 33'(expq.size()), 33'd0);
      chk("done_count", 33'(dones), 33'(nframes));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/zlib_adler_ctrl.md
# zlib_adler_ctrl

Sequencer that wraps the adler32 checksum engine for the zlib stream path of the PNG encoder. It accepts a word-aligned payload stream, forwards each word unchanged downstream, and paces the engine at one word per 4 cycles. After the last payload word it appends the big-endian Adler-32 trailer word. It sits between the IDAT payload builder and the zlib/chunk packer.

## Interface
Parameters:
- DATA_WD, 32, stream word width; fixed, only 32 is supported.
- WAIT_CYC, 3, engine busy cycles after each accepted word.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  frame start pulse; ignored unless in IDLE
- in_val_i  in  1  payload word valid
- in_rdy_o  out  1  payload word accepted when in_val_i && in_rdy_o
- in_dat_i  in  32  payload word; byte [31:24] comes first in the stream
- in_lst_i  in  1  marks the last payload word; sampled on acceptance
- out_val_o  out  1  output word valid
- out_rdy_i  in  1  downstream ready
- out_dat_o  out  32  payload word or trailer word
- out_lst_o  out  1  high on the trailer word only
- busy_o  out  1  high from start acceptance until the trailer is accepted
- done_o  out  1  one-cycle pulse on the trailer handshake

## Operation
- States: IDLE, ARM, FEED, WAIT, LWAIT, TRAIL.
  - IDLE → ARM on start_i. The engine's start is driven the same cycle, which resets its checksum to 0x00000001.
  - ARM → FEED after one cycle, once the engine is ready to accept data.
  - FEED: in_rdy_o = !out_val_o || out_rdy_i.
    - On handshake the word drives the engine's val and dat inputs in the same cycle, with its lst input = in_lst_i.
    - The word is also loaded into the output register.
    - Next state is WAIT, or LWAIT if in_lst_i.
  - WAIT: a 2-bit counter runs WAIT_CYC cycles, then returns to FEED. in_rdy_o = 0.
  - LWAIT: counts WAIT_CYC cycles, then → TRAIL.
  - TRAIL: when the output register is free (!out_val_o || out_rdy_i), load the engine checksum with out_lst_o = 1. On the trailer handshake → IDLE and pulse done_o.
- The engine's val input is asserted only in FEED on a handshake. Outside FEED its data input is 0.
- Output register: 1 entry. out_val_o is set on load and cleared on out_rdy_i when no new load occurs. Data is held stable while out_val_o && !out_rdy_i.
- start_i outside IDLE is ignored. An empty payload is not supported; the first word after start is always payload.
- Reset mid-frame: everything returns to the reset values and the engine returns to IDLE; no trailer is emitted.
- Reset values: in_rdy_o 0, out_val_o 0, out_dat_o 0, out_lst_o 0, busy_o 0, done_o 0, state IDLE, counter 0.

## Timing
- Payload word accepted at cycle t:
  - out_val_o is high at t+1.
  - The next in_rdy_o can be high at t+4, giving a peak rate of 1 word per 4 cycles.
- Start at cycle s: first possible in_rdy_o at s+2.
- Last word accepted at cycle t:
  - The engine checksum is final at t+4.
  - TRAIL is entered at t+4.
  - The trailer is loaded at t+4 if the output register is free, giving out_val_o at t+5.
- Downstream stall: in FEED, in_rdy_o stays 0 while out_val_o && !out_rdy_i. This prevents overrun because the engine only advances on accepted words.
- done_o is registered, high the cycle after the trailer handshake.

## Configuration
- ZLIB_ADLER_CTRL_LEN_CNT_EN
  - Defined: adds output port len_o [31:0], a payload byte count equal to 4 × accepted words.
    - Cleared on start.
    - Saturates at 0xFFFFFFFC.
    - Valid and stable from done_o until the next start.
  - Undefined: the port and counter are absent and all other behaviour is identical.

## Structure
- Shared package zlib_pkg holds:
  - the state enum constants;
  - ADLER_INIT = 32'h0000_0001;
  - ADLER_WAIT_CYC = 3;
  - DATA_WD = 32.
- One sub-module: the adler32 checksum engine, instantiated as u_adler32. Its start, val, dat and lst inputs are driven by this block, and its checksum output feeds TRAIL.
- The output register is inline logic, not a separate module.

## Test plan
- Single word 0x61626364 ("abcd"), out_rdy_i = 1 → out words 0x61626364 then 0x03D8018B with out_lst_o = 1; done_o pulses once.
- Two words 0x00000000, 0x00000000 (last) → trailer 0x00080001; in_rdy_o gaps are exactly 3 cycles.
- One word 0xFFFFFFFF → trailer 0x09FA03FD. This exercises carry in the s1/s2 sums.
- out_rdy_i low for 10 cycles mid-frame:
  - out_dat_o stays stable;
  - in_rdy_o stays 0;
  - the final trailer matches the unstalled run.
- start_i pulsed during WAIT and during TRAIL → ignored. Reset asserted in LWAIT → all outputs 0; a new frame after reset yields the correct checksum.
- With ZLIB_ADLER_CTRL_LEN_CNT_EN defined, 5-word frame → len_o = 20 at done_o.
